fifo_rd_packer: RTL

//  Read-side consumer of the sync FIFO: pops DATA_WIDTH words via rd_en/empty/data_out and

---
 rtl/fifo_pkg.sv | 19 +
 rtl/packer_out_slice.sv | 48 ++++
 rtl/fifo_rd_packer.sv | 111 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and state type for the FIFO read-side packer.
// Imported by the packer top; the output slice is parameter-only.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int RATIO_DEF      = 4;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FL_WAIT = 2'd1,
    FL_EMIT = 2'd2
  } packer_state_e;

  // Lane counter must hold 0..ratio inclusive.
  function automatic int cnt_width(input int ratio);
    return $clog2(ratio + 1);
  endfunction

endpackage

// File: rtl/packer_out_slice.sv
// Single-entry holding register for the packed output stream.
// A load always wins; otherwise a handshake empties the slot while the payload stays put.
module packer_out_slice #(
  parameter int OUT_W  = 32,
  parameter int KEEP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [OUT_W-1:0]  i_data,
  input  logic [KEEP_W-1:0] i_keep,
  input  logic              i_last,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [OUT_W-1:0]  o_data,
  output logic [KEEP_W-1:0] o_keep,
  output logic              o_last,
  output logic              o_slot_free
);

  logic              r_valid;
  logic [OUT_W-1:0]  r_data;
  logic [KEEP_W-1:0] r_keep;
  logic              r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_keep  <= i_keep;
      r_last  <= i_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_slot_free = !r_valid || i_ready;
  assign o_valid     = r_valid;
  assign o_data      = r_data;
  assign o_keep      = r_keep;
  assign o_last      = r_last;

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops narrow words from a sync FIFO and packs RATIO of them into one wide
// valid/ready word; a flush pulse closes a partial word with a lane keep mask.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int RATIO      = RATIO_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        fifo_empty,
  input  logic [DATA_WIDTH-1:0]       fifo_data_out,
  output logic                        fifo_rd_en,
  input  logic                        flush,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_WIDTH*RATIO-1:0] m_data,
  output logic [RATIO-1:0]            m_keep,
  output logic                        m_last
);

  localparam int              OUT_W   = DATA_WIDTH * RATIO;
  localparam int              CW      = cnt_width(RATIO);
  localparam logic [CW-1:0]   RATIO_C = CW'(RATIO);
  localparam logic [CW:0]     RATIO_S = (CW + 1)'(RATIO);

  packer_state_e          r_state;
  logic [CW-1:0]          r_cnt;
  logic                   r_pend;
  logic [DATA_WIDTH-1:0]  r_lane [RATIO];

  logic [DATA_WIDTH-1:0]  w_lane_in [RATIO];
  logic [CW:0]            w_sum;
  logic [CW-1:0]          w_cnt_after;
  logic                   w_slot_free;
  logic                   w_full;
  logic                   w_load_full;
  logic                   w_load_part;
  logic                   w_load;
  logic                   w_ld_last;
  logic [RATIO-1:0]       w_part_keep;
  logic [RATIO-1:0]       w_ld_keep;
  logic [OUT_W-1:0]       w_ld_data;

  // Lanes already filled plus the one read still in flight.
  assign w_sum       = {1'b0, r_cnt} + {{CW{1'b0}}, r_pend};
  assign w_cnt_after = r_cnt + {{(CW-1){1'b0}}, r_pend};

  // A read may overlap the final capture only if that word can leave on the same edge.
  assign fifo_rd_en = rst_n && (r_state == RUN) && !fifo_empty && !flush &&
                      ((w_sum < RATIO_S) ||
                       ((w_sum == RATIO_S) && r_pend && w_slot_free));

  assign w_full      = (w_cnt_after == RATIO_C);
  assign w_load_full = w_full && w_slot_free;
  assign w_load_part = (r_state == FL_EMIT) && (r_cnt != '0) && !w_full && w_slot_free;
  assign w_load      = w_load_full || w_load_part;
  assign w_ld_last   = w_load_part || (r_state != RUN) || flush;
  assign w_ld_keep   = w_load_part ? w_part_keep : '1;

  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    assign w_lane_in[gi]   = (r_pend && (r_cnt == CW'(gi))) ? fifo_data_out : r_lane[gi];
    assign w_part_keep[gi] = (CW'(gi) < r_cnt);
    assign w_ld_data[gi*DATA_WIDTH +: DATA_WIDTH] = w_ld_keep[gi] ? w_lane_in[gi] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < RATIO; k++) r_lane[k] <= '0;
    end else begin
      for (int k = 0; k < RATIO; k++) r_lane[k] <= w_lane_in[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
    end else begin
      r_pend <= fifo_rd_en;
      r_cnt  <= w_load ? '0 : w_cnt_after;
      case (r_state)
        RUN:     if (flush) r_state <= FL_WAIT;
        FL_WAIT: if (!r_pend) r_state <= FL_EMIT;
        // Leaves once empty or once the closing word has been loaded.
        FL_EMIT: if ((r_cnt == '0) || w_slot_free) r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

  packer_out_slice #(
    .OUT_W  (OUT_W),
    .KEEP_W (RATIO)
  ) u_out_slice (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_data      (w_ld_data),
    .i_keep      (w_ld_keep),
    .i_last      (w_ld_last),
    .i_ready     (m_ready),
    .o_valid     (m_valid),
    .o_data      (m_data),
    .o_keep      (m_keep),
    .o_last      (m_last),
    .o_slot_free (w_slot_free)
  );

endmodule
